// File: rtl/aes_fifo_pkg.sv
// aes_fifo_pkg: shared widths, default depth and sizing helpers for the AES block FIFO
package aes_fifo_pkg;
  localparam int AES_WORD_W = 32;
  localparam int AES_BLOCK_W = 128;
  localparam int AES_FIFO_DEPTH = 4;
  function automatic int ptr_width(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/aes_word_packer.sv
// aes_word_packer: gathers RATIO input words MSB-first into one cipher block
module aes_word_packer #(
  parameter int IN_WIDTH = 32,
  parameter int RATIO = 4,
  localparam int OUT_WIDTH = IN_WIDTH * RATIO,
  localparam int PLW = $clog2(RATIO)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 push,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic [PLW-1:0]       pack_level,
  output logic                 block_done,
  output logic [OUT_WIDTH-1:0] block_data
);
  logic [OUT_WIDTH-IN_WIDTH-1:0] sr;
  logic last;
  assign last = pack_level == PLW'(RATIO - 1);
  assign block_done = push && last;
  // the completing word joins the held words combinationally so the block commits on that edge
  assign block_data = {sr, in_data};
  always_ff @(posedge clk or posedge reset)
    if (reset) pack_level <= '0;
    else if (flush) pack_level <= '0;
    else if (push) pack_level <= last ? '0 : pack_level + PLW'(1);
  always_ff @(posedge clk)
    if (push) sr <= block_data[OUT_WIDTH-IN_WIDTH-1:0];
endmodule

// File: rtl/aes_block_fifo.sv
// aes_block_fifo: packs bus words into AES blocks and queues them; AES_FIFO_ERR_FLAGS_EN enables sticky overflow/underflow
module aes_block_fifo
  import aes_fifo_pkg::*;
#(
  parameter int IN_WIDTH = AES_WORD_W,
  parameter int RATIO = AES_BLOCK_W / AES_WORD_W,
  parameter int DEPTH = AES_FIFO_DEPTH,
  parameter int AFULL_THRESH = DEPTH - 1,
  localparam int OUT_WIDTH = IN_WIDTH * RATIO,
  localparam int PW = ptr_width(DEPTH),
  localparam int LW = level_width(DEPTH),
  localparam int PLW = $clog2(RATIO)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic [LW-1:0]        level,
  output logic [PLW-1:0]       pack_level,
  output logic                 almost_full,
  output logic                 overflow,
  output logic                 underflow
);
  logic [OUT_WIDTH-1:0] mem [DEPTH];
  logic [OUT_WIDTH-1:0] block_data;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic push, pop, commit;
  // only the completing word can stall, so partial words never back up the bus
  assign in_ready = pack_level != PLW'(RATIO - 1) || level < LW'(DEPTH);
  assign out_valid = level != '0;
  assign out_data = mem[rd_ptr];
  assign almost_full = level >= LW'(AFULL_THRESH);
  assign push = in_valid && in_ready && !flush;
  assign pop = out_valid && out_ready && !flush;
  aes_word_packer #(.IN_WIDTH(IN_WIDTH), .RATIO(RATIO)) u_packer (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .push(push),
    .in_data(in_data),
    .pack_level(pack_level),
    .block_done(commit),
    .block_data(block_data)
  );
  always_ff @(posedge clk)
    if (commit) mem[wr_ptr] <= block_data;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (commit) wr_ptr <= wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + PW'(1);
      level <= (commit && !pop) ? level + LW'(1) : (pop && !commit) ? level - LW'(1) : level;
    end
`ifdef AES_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (in_valid && !in_ready) overflow <= 1'b1;
      if (out_ready && !out_valid) underflow <= 1'b1;
    end
`else
  assign overflow = 1'b0;
  assign underflow = 1'b0;
`endif
endmodule

// File: tb/tb_aes_block_fifo.sv
// tb_aes_block_fifo: scoreboard bench for the AES block FIFO
module tb_aes_block_fifo;
  localparam int IW = 32, R = 4, D = 4, OW = 128;
`ifdef AES_FIFO_ERR_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset, flush, in_valid, in_ready, out_valid, out_ready, almost_full, overflow, underflow;
  logic [IW-1:0] in_data;
  logic [OW-1:0] out_data;
  logic [2:0] level;
  logic [1:0] pack_level;
  int n_checks = 0, n_fail = 0;
  int m_pack = 0, m_level = 0, n_pops = 0, pops0;
  bit m_ovf = 0, m_unf = 0;
  logic [OW-1:0] m_acc = '0;
  logic [OW-1:0] sb[$];
  always #5 clk = ~clk;
  aes_block_fifo dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .pack_level(pack_level), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow)
  );
  task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    bit rdy, push, pop, ovf_ev, unf_ev;
    rdy = m_pack != R - 1 || m_level < D;
    push = in_valid && rdy && !flush;
    pop = out_ready && m_level != 0 && !flush;
    ovf_ev = in_valid && !rdy;
    unf_ev = out_ready && m_level == 0;
    check("in_ready", in_ready, rdy);
    check("out_valid", out_valid, m_level != 0);
    if (pop && sb.size() != 0) begin
      check("out_data", out_data, sb.pop_front());
      n_pops++;
    end
    @(posedge clk);
    #1;
    if (flush) begin
      m_pack = 0; m_level = 0; m_ovf = 0; m_unf = 0;
      sb.delete();
    end else begin
      if (push) begin
        m_acc = {m_acc[OW-IW-1:0], in_data};
        if (m_pack == R - 1) begin
          m_pack = 0;
          m_level++;
          sb.push_back(m_acc);
        end else m_pack++;
      end
      if (pop) m_level--;
      m_ovf |= ovf_ev;
      m_unf |= unf_ev;
    end
    check("level", level, m_level);
    check("pack_level", pack_level, m_pack);
    check("almost_full", almost_full, m_level >= D - 1);
    check("overflow", overflow, FLAGS && m_ovf);
    check("underflow", underflow, FLAGS && m_unf);
  endtask
  task automatic push_word(input logic [IW-1:0] w);
    in_valid = 1'b1;
    in_data = w;
    step();
    in_valid = 1'b0;
  endtask
  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask
  initial begin
    logic [IW-1:0] t1 [4];
    t1 = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_level", level, 0);
    check("rst_pack", pack_level, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_afull", almost_full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_unf", underflow, 0);
    reset = 1'b0;
    // basic block ordering
    for (int i = 0; i < 4; i++) push_word(t1[i]);
    check("t1_data", out_data, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    check("t1_level", level, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    // fill to full and overrun
    for (int i = 0; i < 19; i++) push_word($urandom);
    check("fill_level", level, 4);
    check("fill_afull", almost_full, 1);
    check("fill_pack", pack_level, 3);
    in_valid = 1'b1;
    in_data = $urandom;
    step();
    check("full_in_ready", in_ready, 0);
    check("full_ovf", overflow, FLAGS);
    out_ready = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    repeat (3) step();
    out_ready = 1'b0;
    do_flush();
    // streaming
    pops0 = n_pops;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_data = $urandom;
      step();
      check("stream_lvl_max", level <= 1, 1);
    end
    in_valid = 1'b0;
    step();
    check("stream_pops", n_pops - pops0, 10);
    out_ready = 1'b0;
    do_flush();
    // flush with held data
    for (int i = 0; i < 10; i++) push_word($urandom);
    check("pre_flush_level", level, 2);
    in_valid = 1'b1;
    out_ready = 1'b1;
    in_data = $urandom;
    do_flush();
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("flush_level", level, 0);
    check("flush_pack", pack_level, 0);
    check("flush_out_valid", out_valid, 0);
    for (int i = 0; i < 4; i++) push_word($urandom);
    out_ready = 1'b1;
    step();
    // underflow on empty
    step();
    check("unf_level", level, 0);
    check("unf_flag", underflow, FLAGS);
    out_ready = 1'b0;
    do_flush();
    check("unf_cleared", underflow, 0);
    // reset mid-block
    push_word($urandom);
    push_word($urandom);
    reset = 1'b1;
    #1;
    check("arst_level", level, 0);
    check("arst_pack", pack_level, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    m_pack = 0; m_level = 0; m_ovf = 0; m_unf = 0;
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) push_word($urandom);
    check("post_rst_level", level, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("post_rst_pack", pack_level, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/aes_block_fifo.md
# aes_block_fifo

Parametrised input buffer for the AES-256 core. It packs a stream of narrow bus words into full cipher blocks and queues whole blocks for the round engine. The block sits between the bus-side write interface and the AES datapath, and replaces the fixed 4×32-bit word FIFO. Depth, word width and words-per-block are parameters, both sides use valid/ready handshakes, and it adds flush, almost-full and level reporting.

## Interface
Parameters:
- IN_WIDTH, 32: width of one input word.
- RATIO, 4: input words per output block; output width is OUT_WIDTH = IN_WIDTH*RATIO (128 by default).
- DEPTH, 4: number of complete blocks stored. Any value ≥ 2 is legal; powers of two are not required.
- AFULL_THRESH, DEPTH-1: block count at or above which `almost_full` asserts.

Ports:
- clk, in, 1: single clock, rising edge.
- reset, in, 1: asynchronous, active-high reset.
- flush, in, 1: synchronous clear of all stored data and the partial block.
- in_valid, in, 1: input word valid.
- in_ready, out, 1: block accepts a word this cycle.
- in_data, in, IN_WIDTH: input word.
- out_valid, out, 1: a complete block is available.
- out_ready, in, 1: consumer takes the block this cycle.
- out_data, out, OUT_WIDTH: head block, first-word-fall-through.
- level, out, $clog2(DEPTH+1): number of complete blocks stored.
- pack_level, out, $clog2(RATIO): number of words held in the partial block.
- almost_full, out, 1: asserted when level ≥ AFULL_THRESH.
- overflow, out, 1: sticky error flag (see Configuration).
- underflow, out, 1: sticky error flag (see Configuration).

## Operation
- Push: a word is accepted when in_valid && in_ready.
- Word packing: the first accepted word of a block lands in out bits [OUT_WIDTH-1 : OUT_WIDTH-IN_WIDTH], i.e. MSB-first, matching AES state column order. Each following word fills the next lower slice.
- Block commit: accepting word RATIO-1 completes the block. On the same edge the block is written to storage at wr_ptr, pack_level returns to 0 and level increments.
- in_ready = (pack_level != RATIO-1) || (level < DEPTH). Partial words are always accepted; only the completing word stalls when storage is full. in_ready has no combinational path from out_ready.
- Pop: occurs when out_valid && out_ready. rd_ptr advances and level decrements.
- out_valid = (level != 0). out_data = storage[rd_ptr]; it is stable while out_valid is high and no pop occurs.
- Pointer wrap: both pointers wrap from DEPTH-1 to 0.
- Simultaneous commit and pop: level is unchanged and both pointers advance.
- Commit when level == DEPTH: impossible, because in_ready is low. A pop in that same cycle does not re-enable the push; it is accepted on the next cycle.
- flush:
  - Clears level, pack_level, both pointers and the sticky flags.
  - A push or pop in the flush cycle is discarded.
  - Storage contents are not cleared.
- Reset (asynchronous, active-high): immediately forces the outputs to level=0, pack_level=0, out_valid=0, in_ready=1, almost_full=0 (when AFULL_THRESH>0), overflow=0, underflow=0. out_data is undefined until the first commit.
- Reset mid-block: the partial block is lost. No output handshake completes while reset is high.

## Timing
- Latency: the last word is accepted at edge N; out_valid and the new out_data are visible after edge N, and the block can be popped at edge N+1.
- Throughput: one word per cycle in, one block per cycle out.
- All outputs are registered, or decoded purely from registered state.

## Configuration
- Macro AES_FIFO_ERR_FLAGS_EN, when defined:
  - overflow sets on in_valid && !in_ready.
  - underflow sets on out_ready && !out_valid.
  - Both flags hold until reset or flush.
- When the macro is undefined, overflow and underflow are tied to 0 and the tracking logic is omitted. The ports remain present in both builds.

## Structure
- Package aes_fifo_pkg holds:
  - Default constants AES_WORD_W=32 and AES_BLOCK_W=128.
  - Default depth.
  - Helper functions for pointer width (clog2 of DEPTH, minimum 1) and level width.
- Sub-module aes_word_packer holds:
  - The partial-block shift register.
  - The pack_level counter.
  - A block_done strobe that feeds the storage write.
- Top level holds the storage array, pointers, level counter and flags.

## Test plan
- Reset, then push 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF → out_valid high the cycle after the fourth push; out_data = 0x00112233_44556677_8899AABB_CCDDEEFF; level=1.
- Fill with out_ready=0:
  - After 16 words (4 blocks): level=4, almost_full=1.
  - Words 17–19 are accepted and pack_level reaches 3.
  - Word 20 sees in_ready=0 and, with the macro, overflow=1.
- Streaming: in_valid=1 and out_ready=1 continuously for 40 words → 10 blocks popped in order, level never exceeds 1, and both pointers wrap at least twice.
- flush with 2 blocks and 2 partial words held → the next cycle shows level=0, pack_level=0, out_valid=0; the next 4 words form a clean block.
- out_ready pulsed while empty → no pop occurs and level stays 0. With the macro, underflow=1; after flush, underflow=0.
- Assert reset after 2 words of a block → outputs return to reset values immediately. The next 4 words after release form one block, with no leftover words.
